// File: rtl/cskipa_pkg.sv
// ============================================================================
// Module  : cskipa_pkg
// Brief   : Shared width, opcode encoding and saturation value for the
//           carry-skip accumulator slice.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package cskipa_pkg;

  localparam int CSKIPA_WIDTH = 17;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ACC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } cskipa_op_t;

  localparam logic [CSKIPA_WIDTH-1:0] CSKIPA_SAT_VAL = '1;

endpackage

`default_nettype wire

// File: rtl/cskipa_accum_17bit_adder.sv
// ============================================================================
// Module  : CSkipA_17bit
// Brief   : 17-bit carry-skip adder, 4-bit ripple blocks with block bypass.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module CSkipA_17bit
  import cskipa_pkg::*;
(
  input  logic [CSKIPA_WIDTH-1:0] i_a,
  input  logic [CSKIPA_WIDTH-1:0] i_b,
  input  logic                    i_cin,
  output logic [CSKIPA_WIDTH-1:0] o_sum,
  output logic                    o_cout
);

  localparam int BLK = 4;

  logic [CSKIPA_WIDTH-1:0] sum_w;
  logic                    c_w;
  logic                    cin_blk_w;
  logic                    pall_w;
  logic                    p_w;

  // A block whose bits all propagate forwards its own carry-in unchanged.
  always_comb begin
    sum_w     = '0;
    c_w       = i_cin;
    cin_blk_w = i_cin;
    pall_w    = 1'b1;
    p_w       = 1'b0;
    for (int k = 0; k < CSKIPA_WIDTH; k++) begin
      if ((k % BLK) == 0) begin
        cin_blk_w = c_w;
        pall_w    = 1'b1;
      end
      p_w      = i_a[k] ^ i_b[k];
      sum_w[k] = p_w ^ c_w;
      c_w      = (i_a[k] & i_b[k]) | (p_w & c_w);
      pall_w   = pall_w & p_w;
      if (((k % BLK) == (BLK - 1)) || (k == CSKIPA_WIDTH - 1)) begin
        c_w = pall_w ? cin_blk_w : c_w;
      end
    end
  end

  assign o_sum  = sum_w;
  assign o_cout = c_w;

endmodule

`default_nettype wire

// File: rtl/cskipa_accum_17bit.sv
// ============================================================================
// Module  : cskipa_accum_17bit
// Brief   : Two-stage valid/ready accumulator around CSkipA_17bit.
//           Define CSKIPA_SAT_EN to saturate overflowing ACC results.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cskipa_accum_17bit
  import cskipa_pkg::*;
#(
  parameter int WIDTH = CSKIPA_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic [WIDTH-1:0] o_acc,
  output logic             o_ovf,
  output logic [CNT_W-1:0] o_count
);

  logic             s1_valid_q, s1_valid_d;
  cskipa_op_t       s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             cout_q,     cout_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic             ovf_q,      ovf_d;
  logic [CNT_W-1:0] count_q,    count_d;

  logic             out_adv_w;
  logic             s1_move_w;
  logic             accept_w;
  logic [WIDTH-1:0] add_b_w;
  logic [WIDTH-1:0] add_sum_w;
  logic             add_cout_w;

  assign out_adv_w = !out_valid_q || i_ready;
  assign s1_move_w = s1_valid_q && out_adv_w;
  assign o_ready   = !s1_valid_q || out_adv_w;
  assign accept_w  = i_valid && o_ready;

  // ACC folds the running accumulator in as the second operand.
  assign add_b_w = (s1_op_q == OP_ACC) ? acc_q : s1_b_q;

  CSkipA_17bit u_adder (
    .i_a    (s1_a_q),
    .i_b    (add_b_w),
    .i_cin  (1'b0),
    .o_sum  (add_sum_w),
    .o_cout (add_cout_w)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    count_d     = count_q;

    if (accept_w) begin
      s1_valid_d = 1'b1;
      s1_op_d    = cskipa_op_t'(i_op);
      s1_a_d     = i_add_term1;
      s1_b_d     = i_add_term2;
    end else if (s1_move_w) begin
      s1_valid_d = 1'b0;
    end

    if (out_adv_w) begin
      out_valid_d = s1_valid_q;
    end

    if (s1_move_w) begin
      count_d = count_q + CNT_W'(1);
      unique case (s1_op_q)
        OP_ADD: begin
          sum_d  = add_sum_w;
          cout_d = add_cout_w;
        end
        OP_ACC: begin
`ifdef CSKIPA_SAT_EN
          sum_d = add_cout_w ? CSKIPA_SAT_VAL : add_sum_w;
          acc_d = add_cout_w ? CSKIPA_SAT_VAL : add_sum_w;
`else
          sum_d = add_sum_w;
          acc_d = add_sum_w;
`endif
          cout_d = add_cout_w;
          if (add_cout_w) ovf_d = 1'b1;
        end
        OP_LOAD: begin
          sum_d  = s1_a_q;
          cout_d = 1'b0;
          acc_d  = s1_a_q;
          ovf_d  = 1'b0;
        end
        OP_CLR: begin
          sum_d  = '0;
          cout_d = 1'b0;
          acc_d  = '0;
          ovf_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_acc   = acc_q;
  assign o_ovf   = ovf_q;
  assign o_count = count_q;

endmodule

`default_nettype wire
